// File: rtl/riscv_enc_pkg.sv
// Shared constants for the RV32 instruction encoder: format codes, opcodes,
// immediate range limits and the packer result bundle.
package riscv_enc_pkg;

    localparam logic [1:0] FMT_R  = 2'd0;
    localparam logic [1:0] FMT_I  = 2'd1;
    localparam logic [1:0] FMT_S  = 2'd2;
    localparam logic [1:0] FMT_SB = 2'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // 12-bit immediates (I, S) and 13-bit even branch offsets (SB)
    localparam longint IMM12_MIN = -64'sd2048;
    localparam longint IMM12_MAX = 64'sd2047;
    localparam longint IMM13_MIN = -64'sd4096;
    localparam longint IMM13_MAX = 64'sd4094;

    typedef struct packed {
        logic [31:0] instr;
        logic        legal;
    } packed_word_t;

    function automatic logic imm_in_range(logic [63:0] imm, longint lo, longint hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Combinational RV32 field packer: builds the R/I/S/SB instruction word and
// flags immediates that do not fit the chosen format.
module inst_field_packer
    import riscv_enc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    packed_word_t word;

    always_comb begin
        word = '0;
        unique case (fmt)
            FMT_R: begin
                word.instr = {funct7, rs2, rs1, funct3, rd, opcode};
                word.legal = 1'b1;
            end
            FMT_I: begin
                word.instr = {imm[11:0], rs1, funct3, rd, opcode};
                word.legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                word.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                word.legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_SB: begin
                word.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                // Branch offsets are halfword-aligned; bit 0 is not encoded
                word.legal = imm_in_range(imm, IMM13_MIN, IMM13_MAX) && !imm[0];
            end
            default: begin
                word = '0;
            end
        endcase
    end

    assign instr = word.instr;
    assign legal = word.legal;

endmodule

// File: rtl/instruction_encoder_loader.sv
// Streams encoded RV32 words with ascending wrap-around addresses into
// instruction memory; illegal bundles are consumed and counted instead.
module instruction_encoder_loader
    import riscv_enc_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              wrapped,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [31:0] enc_instr;
    logic        enc_legal;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic accept;
    logic drain;

    inst_field_packer u_packer (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (enc_instr),
        .legal  (enc_legal)
    );

    // The output slot frees up in the same cycle it is drained
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready;

    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        wrapped_d   = wrapped_q;
        err_pulse_d = accept && !enc_legal;
        err_cnt_d   = err_cnt_q;

        if (drain) begin
            valid_d = 1'b0;
            if (addr_q == LAST_ADDR) begin
                addr_d    = '0;
                wrapped_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (accept && enc_legal) begin
            valid_d = 1'b1;
            instr_d = enc_instr;
        end

        if (accept && !enc_legal && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
            wrapped_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            wrapped_q   <= wrapped_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign wrapped   = wrapped_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Self-checking bench: vector table plus scoreboard for words, addresses,
// wrap, stall hold, error counting and mid-stream reset.
module tb_instruction_encoder_loader;
    import riscv_enc_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned ERR_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_fmt = '0;
    logic [6:0]        in_opcode = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [2:0]        in_funct3 = '0;
    logic [6:0]        in_funct7 = '0;
    logic [63:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              wrapped;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;

    instruction_encoder_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .ERR_W  (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .wrapped   (wrapped),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [31:0] instr;
        logic        legal;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] mon_addr = '0;
    logic              mon_wrapped = 1'b0;
    logic [ERR_W-1:0]  err_model = '0;
    logic              held_v = 1'b0;
    logic [31:0]       held_instr;
    logic [ADDR_W-1:0] held_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [1:0] fmt, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [63:0] imm,
                                logic [31:0] instr, logic legal);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.instr = instr; v.legal = legal;
        return v;
    endfunction

    // Scoreboard: every drained word is popped and checked with the model address
    always @(negedge clk) begin
        if (!rst && held_v && out_valid) begin
            chk("hold_instr", 64'(out_instr), 64'(held_instr));
            chk("hold_addr", 64'(out_addr), 64'(held_addr));
        end
        held_v     = !rst && out_valid && !out_ready;
        held_instr = out_instr;
        held_addr  = out_addr;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(out_instr), 64'hDEAD_BEEF_0000_0000);
            end else begin
                chk("word_instr", 64'(out_instr), 64'(exp_q.pop_front()));
                chk("word_addr", 64'(out_addr), 64'(mon_addr));
                chk("word_wrapped", 64'(wrapped), 64'(mon_wrapped));
                if (mon_addr == ADDR_W'(DEPTH - 1)) begin
                    mon_addr    = '0;
                    mon_wrapped = 1'b1;
                end else begin
                    mon_addr = mon_addr + 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        mon_addr    = '0;
        mon_wrapped = 1'b0;
        err_model   = '0;
    endtask

    task automatic send(input vec_t v);
        logic got;
        int   n;
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            #1;
            got = in_ready;
            if (got && v.legal) exp_q.push_back(v.instr);
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        chk("err_pulse", 64'(err_pulse), 64'(!v.legal));
        if (!v.legal && err_model != {ERR_W{1'b1}}) err_model = err_model + 1'b1;
        chk("err_count", 64'(err_count), 64'(err_model));
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(FMT_R, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 32'h002081B3, 1'b1));
        vecs.push_back(mk(FMT_I, OP_I_ALU, 5'd5, 5'd6, 5'd0, 3'd0, 7'h7F,
                          64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF30293, 1'b1));
        vecs.push_back(mk(FMT_I, OP_I_ALU, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 64'd2048, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_S, OP_STORE, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 64'd8, 32'h00712423, 1'b1));
        vecs.push_back(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd16, 32'h00208863, 1'b1));
        vecs.push_back(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_I, OP_LOAD, 5'd10, 5'd11, 5'd0, 3'd2, 7'd0, 64'd2047, 32'h7FF5A503, 1'b1));
        vecs.push_back(mk(FMT_I, OP_I_ALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                          64'hFFFF_FFFF_FFFF_F800, 32'h80000093, 1'b1));
        vecs.push_back(mk(FMT_I, OP_I_ALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                          64'hFFFF_FFFF_FFFF_F7FF, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_S, OP_STORE, 5'd0, 5'd0, 5'd31, 3'd2, 7'd0,
                          64'hFFFF_FFFF_FFFF_F800, 32'h81F02023, 1'b1));
        vecs.push_back(mk(FMT_S, OP_STORE, 5'd0, 5'd0, 5'd31, 3'd2, 7'd0, 64'd2048, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,
                          64'hFFFF_FFFF_FFFF_F000, 32'h80001063, 1'b1));
        vecs.push_back(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4094, 32'h7E000FE3, 1'b1));
        vecs.push_back(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4096, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                          64'hFFFF_FFFF_FFFF_EFFE, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_I, OP_I_ALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                          64'h0000_0001_0000_0005, 32'h0, 1'b0));
        vecs.push_back(mk(FMT_R, OP_R, 5'd31, 5'd31, 5'd31, 3'd0, 7'h20,
                          64'h8000_0000_0000_0001, 32'h41FF8FB3, 1'b1));

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_wrapped", 64'(wrapped), 64'd0);
        chk("rst_err_pulse", 64'(err_pulse), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table: one bundle at a time, output always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i]);
            if (!vecs[i].legal) begin
                chk("illegal_no_valid", 64'(out_valid), 64'd0);
                chk("illegal_addr_hold", 64'(out_addr), 64'(mon_addr));
            end else begin
                chk("legal_valid", 64'(out_valid), 64'd1);
            end
            tick();
        end
        repeat (2) tick();
        chk("table_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back stream with a 3-cycle stall and an address wrap
        do_reset();
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    send(mk(FMT_I, OP_I_ALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'(k),
                            (32'(k) << 20) | 32'h0000_0093, 1'b1));
                end
            end
            begin
                repeat (2) tick();
                out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) tick();
        chk("stream_drained", 64'(exp_q.size()), 64'd0);
        chk("stream_wrapped", 64'(wrapped), 64'd1);
        chk("stream_addr", 64'(out_addr), 64'd1);

        // Error counter saturates
        for (int k = 0; k < 5; k++) begin
            send(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 32'h0, 1'b0));
        end
        chk("err_saturated", 64'(err_count), 64'd3);
        tick();
        chk("err_pulse_clears", 64'(err_pulse), 64'd0);

        // Reset while a word is held under stall
        out_ready = 1'b0;
        send(mk(FMT_R, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 32'h002081B3, 1'b1));
        tick();
        chk("stalled_valid", 64'(out_valid), 64'd1);
        chk("stalled_instr", 64'(out_instr), 64'h002081B3);
        do_reset();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_addr", 64'(out_addr), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        chk("midrst_wrapped", 64'(wrapped), 64'd0);
        chk("midrst_out_instr", 64'(out_instr), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("midrst_no_output", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
